// File: rtl/comp_pkg.sv
// Shared comparator definitions: class encodings and flag classification.
// Reused by the stat collector, the comparator bench and later comparator blocks.
package comp_pkg;

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_GT   = 2'd1;
    localparam logic [1:0] CLS_EQ   = 2'd2;
    localparam logic [1:0] CLS_LT   = 2'd3;

    typedef enum logic [1:0] {
        RUN_NONE = 2'd0,
        RUN_GT   = 2'd1,
        RUN_EQ   = 2'd2,
        RUN_LT   = 2'd3
    } run_e;

    typedef struct packed {
        logic       illegal;
        logic [1:0] cls;
    } cls_res_t;

    // One-hot flags map to a class; any other pattern is illegal.
    function automatic cls_res_t cls_of(input logic s1,
                                        input logic s2,
                                        input logic s3);
        cls_res_t r;
        r.illegal = 1'b0;
        r.cls     = CLS_NONE;
        case ({s1, s2, s3})
            3'b100:  r.cls = CLS_GT;
            3'b010:  r.cls = CLS_EQ;
            3'b001:  r.cls = CLS_LT;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/comp_stat_collector_if.sv
// Sample/statistics bundle of comp_stat_collector.
// master: drives in_valid, s1..s3, clr; slave: drives the statistics outputs.
interface comp_stat_collector_if #(
    parameter int CNT_W = 8,
    parameter int RUN_W = 4
);
    logic             in_valid;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             clr;
    logic [CNT_W-1:0] n_gt;
    logic [CNT_W-1:0] n_eq;
    logic [CNT_W-1:0] n_lt;
    logic [CNT_W-1:0] n_err;
    logic [1:0]       run_cls;
    logic [RUN_W-1:0] run_len;
    logic [RUN_W-1:0] run_max;
    logic             err;
    logic             sat;

    modport master (
        output in_valid, s1, s2, s3, clr,
        input  n_gt, n_eq, n_lt, n_err,
        input  run_cls, run_len, run_max, err, sat
    );

    modport slave (
        input  in_valid, s1, s2, s3, clr,
        output n_gt, n_eq, n_lt, n_err,
        output run_cls, run_len, run_max, err, sat
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with clear-and-count in one edge.
// Ports: clk, rst (sync), clr, inc; o_count (registered), o_next, o_ovf (blocked inc).
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] o_count,
    output logic [W-1:0] o_next,
    output logic         o_ovf
);
    localparam logic [W-1:0] MAX = '1;
    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_count;
    logic [W-1:0] w_base;
    logic         w_full;

    // clr with inc restarts the count at 1 (used for run restarts).
    assign w_base  = clr ? '0 : r_count;
    assign w_full  = (w_base == MAX);
    assign o_next  = (inc && !w_full) ? w_base + ONE : w_base;
    assign o_ovf   = inc && w_full;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            r_count <= o_next;
        end
    end
endmodule

// File: rtl/comp_stat_collector.sv
// Classifies comparator flag samples; keeps saturating class counts and run stats.
// Ports: clk, rst (sync, active high), bus (comp_stat_collector_if.slave).
module comp_stat_collector
    import comp_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int RUN_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    comp_stat_collector_if.slave  bus
);
    cls_res_t         w_c;
    logic             w_smp;
    logic             w_legal;
    logic             w_restart;
    logic [3:0]       w_inc;
    logic [4:0]       w_ovf;
    logic [RUN_W-1:0] w_run_next;
    logic [CNT_W-1:0] w_cnt_next [4];
    logic [CNT_W-1:0] w_cnt [4];

    run_e             r_run_cls;
    logic [RUN_W-1:0] r_run_max;
    logic             r_err;
    logic             r_sat;

    assign w_c     = cls_of(bus.s1, bus.s2, bus.s3);
    // A clear discards the sample on the same edge.
    assign w_smp   = bus.in_valid && !bus.clr;
    assign w_legal = w_smp && !w_c.illegal;

    assign w_inc[0] = w_legal && (w_c.cls == CLS_GT);
    assign w_inc[1] = w_legal && (w_c.cls == CLS_EQ);
    assign w_inc[2] = w_legal && (w_c.cls == CLS_LT);
    assign w_inc[3] = w_smp && w_c.illegal;

    for (genvar g = 0; g < 4; g++) begin : g_cnt
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .clr     (bus.clr),
            .inc     (w_inc[g]),
            .o_count (w_cnt[g]),
            .o_next  (w_cnt_next[g]),
            .o_ovf   (w_ovf[g])
        );
    end

    // Illegal or class change restarts the run; from NONE any legal class differs.
    assign w_restart = w_smp
                     && (w_c.illegal || (w_c.cls != r_run_cls));

    sat_counter #(.W(RUN_W)) u_run (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.clr || w_restart),
        .inc     (w_legal),
        .o_count (bus.run_len),
        .o_next  (w_run_next),
        .o_ovf   (w_ovf[4])
    );

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_run_cls <= RUN_NONE;
            r_run_max <= '0;
            r_err     <= 1'b0;
            r_sat     <= 1'b0;
        end else if (bus.in_valid) begin
            r_run_cls <= w_c.illegal ? RUN_NONE : run_e'(w_c.cls);
            r_err     <= r_err || w_c.illegal;
            r_sat     <= r_sat || (|w_ovf);
            // Compared against the post-edge run length, so a restart offers 1.
            if (w_run_next > r_run_max) begin
                r_run_max <= w_run_next;
            end
        end
    end

    assign bus.n_gt    = w_cnt[0];
    assign bus.n_eq    = w_cnt[1];
    assign bus.n_lt    = w_cnt[2];
    assign bus.n_err   = w_cnt[3];
    assign bus.run_cls = r_run_cls;
    assign bus.run_max = r_run_max;
    assign bus.err     = r_err;
    assign bus.sat     = r_sat;

    logic w_unused;
    assign w_unused = ^{w_cnt_next[0], w_cnt_next[1],
                        w_cnt_next[2], w_cnt_next[3]};
endmodule

// File: doc/comp_stat_collector.md
# comp_stat_collector

Downstream consumer of the 2-bit comparator (`comp_2bit`). It samples the comparator's three flags whenever a valid strobe is high and classifies each sample as greater, equal, less or illegal. It keeps saturating per-class counts and tracks the current and longest run of identical results, so long exhaustive sweeps can be checked in hardware rather than by waveform inspection.

## Interface
Parameters:
- `CNT_W`, 8: width of each per-class counter.
- `RUN_W`, 4: width of the run-length trackers.

Ports:
- `clk`, input, 1: single clock; all logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: sample `s1`/`s2`/`s3` this cycle.
- `s1`, input, 1: comparator a>b flag.
- `s2`, input, 1: comparator a==b flag.
- `s3`, input, 1: comparator a<b flag.
- `clr`, input, 1: synchronous statistics clear, same effect as `rst`.
- `n_gt`, output, CNT_W: count of GT samples.
- `n_eq`, output, CNT_W: count of EQ samples.
- `n_lt`, output, CNT_W: count of LT samples.
- `n_err`, output, CNT_W: count of illegal samples.
- `run_cls`, output, 2: class of the current run (NONE=0, GT=1, EQ=2, LT=3).
- `run_len`, output, RUN_W: length of the current run.
- `run_max`, output, RUN_W: longest run seen since clear.
- `err`, output, 1: sticky; set on the first illegal sample.
- `sat`, output, 1: sticky; set when any counter or run tracker would exceed its maximum.

## Operation
- **Classification** of a sample with `in_valid`=1:
  - Exactly one of `s1`/`s2`/`s3` high gives GT, EQ or LT respectively.
  - Zero or more than one flag high gives ILLEGAL.
- **Per-class counts.** The matching counter increments by 1 and saturates at 2^CNT_W−1. A blocked increment sets `sat`.
- **Run FSM.** States are NONE, GT, EQ and LT, encoded in `run_cls`.
  - Legal sample, same class as `run_cls`: `run_len`+1, saturating at 2^RUN_W−1. A blocked increment sets `sat`.
  - Legal sample, different class or from NONE: go to the sample's class with `run_len`=1.
  - ILLEGAL sample: increment `n_err`, set `err`, go to NONE with `run_len`=0.
  - `run_max` takes the new `run_len` whenever the new value is greater.
- **Idle cycles.** With `in_valid`=0, all state holds. Gaps do not break a run.
- **Clear.** `clr`=1 zeroes every output at the edge and discards any simultaneous sample.
- **Priority:** `rst` > `clr` > `in_valid`.

## Timing
- **Reset values.** On the first edge with `rst`=1, every output becomes 0 (counts, `run_cls`=NONE, `run_len`, `run_max`, `err`, `sat`).
- **Latency.** All outputs are registered. A sample taken at edge N is reflected in the outputs after edge N. There is no combinational path from inputs to outputs.
- **Throughput.** One sample per cycle, back-to-back; there is no ready/backpressure.
- **Reset or clear mid-run.** The in-progress run is dropped and the edge's sample is not counted. Counting resumes with the next valid sample on the following edge.
- **Simultaneous update.** `run_max` update and run-class change in the same edge: `run_max` compares against the new `run_len` (1), never the length of the run just ended.
- **Saturation** is held until `rst`/`clr`. Counters never wrap.

## Structure
- **Shared package `comp_pkg`:**
  - class-encoding localparams `CLS_NONE`/`CLS_GT`/`CLS_EQ`/`CLS_LT`;
  - function `cls_of(s1,s2,s3)` returning a class plus an illegal indication.
  - The comparator bench and future comparator blocks reuse this package.
- **Sub-module `sat_counter`:**
  - parameter width; inputs `clk`, `rst`, `clr`, `inc`; outputs count and overflow pulse.
  - Instantiated four times for the class counters and once for `run_len`.
  - The FSM, `run_max` and the sticky flags stay in the top module.

## Test plan
- **Reset.** Drive `rst` high for 2 cycles with random flags and `in_valid`=1 → all outputs 0, `run_cls`=0.
- **Exhaustive sweep.** Feed the exhaustive `comp_2bit` sweep (a outer 0..3, b inner 0..3, 16 valid cycles back-to-back) → `n_gt`=6, `n_eq`=4, `n_lt`=6, `n_err`=0, `run_max`=3, final `run_cls`=EQ, `run_len`=1, `err`=0.
- **Illegal samples.** Flags 3'b110 then 3'b000 (valid) mid-LT-run of length 2 → `n_err`=2, `err`=1, `run_cls`=NONE, `run_len`=0, `run_max`=2.
- **Saturation.** With `CNT_W`=4 and `RUN_W`=3, 20 consecutive GT samples → `n_gt`=15, `run_len`=7, `run_max`=7, `sat`=1, other counts 0.
- **Gaps and clear.** GT, idle 5 cycles, GT → `run_len`=2. Then `clr` asserted together with a valid EQ → all outputs 0 next cycle, `n_eq`=0.
- **Priority.** `rst` and `clr` together with a valid sample → outputs 0. Deassert both and apply one LT → `n_lt`=1, `run_cls`=LT.
